// File: rtl/multiplicador_n.sv
// multiplicador_n -- multi-cycle unsigned shift-and-add multiplier.
//
// Wraps an N-bit ripple adder and runs one add/shift iteration per clock.
// A 2N-bit product is available after N iterations. The control unit sees a
// start/busy/done handshake.
//
// Ports:
//   clk     system clock, rising edge
//   rst_n   asynchronous active-low reset
//   start   request, sampled only while idle
//   A_num   multiplicand (N bits), latched on an accepted start
//   B_num   multiplier (N bits), latched on an accepted start
//   busy    high while iterating
//   done    one-cycle pulse, result valid
//   result  2N-bit product, held until the next completion
//
// Optional build macro:
//   MULT_ZERO_BYPASS_EN  a zero operand skips the iterations. The result is 0
//                        and done rises one cycle after the start is accepted.

module ripple_adder_n #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         carry_in,
  output logic [N-1:0] sum,
  output logic         carry_out
);

  logic [N:0] carry;

  assign carry[0] = carry_in;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign carry_out = carry[N];

endmodule

// state  | meaning
// IDLE   | waiting for start; operands are latched on an accepted start
// CALC   | one add/shift iteration per clock, N iterations in total
// DONE   | product valid, done pulse for one cycle, then back to IDLE
module multiplicador_n #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   A_num,
  input  logic [N-1:0]   B_num,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] result
);

  localparam int              CW       = $clog2(N + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t         state_q, state_n;
  logic [N-1:0]   m_q, m_n;
  logic [N-1:0]   acc_q, acc_n;
  logic [N-1:0]   q_q, q_n;
  logic           c_q, c_n;
  logic [CW-1:0]  cnt_q, cnt_n;
  logic [2*N-1:0] result_q, result_n;

  logic [N-1:0]   add_b;
  logic [N-1:0]   add_sum;
  logic           add_cout;

  // Every shift clears C, so C is always 0 when it reaches carry_in.
  assign add_b = q_q[0] ? m_q : '0;

  ripple_adder_n #(.N(N)) u_adder (
    .a         (acc_q),
    .b         (add_b),
    .carry_in  (c_q),
    .sum       (add_sum),
    .carry_out (add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      m_q      <= '0;
      acc_q    <= '0;
      q_q      <= '0;
      c_q      <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_n;
      m_q      <= m_n;
      acc_q    <= acc_n;
      q_q      <= q_n;
      c_q      <= c_n;
      cnt_q    <= cnt_n;
      result_q <= result_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    m_n      = m_q;
    acc_n    = acc_q;
    q_n      = q_q;
    c_n      = c_q;
    cnt_n    = cnt_q;
    result_n = result_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          m_n   = A_num;
          q_n   = B_num;
          acc_n = '0;
          c_n   = 1'b0;
          cnt_n = '0;
`ifdef MULT_ZERO_BYPASS_EN
          if ((A_num == '0) || (B_num == '0)) begin
            result_n = '0;
            state_n  = S_DONE;
          end else begin
            state_n = S_CALC;
          end
`else
          state_n = S_CALC;
`endif
        end
      end
      S_CALC: begin
        // The carry_out shifts into the ACC MSB and the sum LSB shifts into Q.
        // The multiplier bit that was just used drops off the bottom of Q.
        {acc_n, q_n} = {add_cout, add_sum, q_q[N-1:1]};
        c_n          = 1'b0;
        cnt_n        = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          result_n = {add_cout, add_sum, q_q[N-1:1]};
          state_n  = S_DONE;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  assign busy   = (state_q == S_CALC);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_multiplicador_n.sv
module tb_multiplicador_n;

  localparam int N = 4;

`ifdef MULT_ZERO_BYPASS_EN
  localparam int ZERO_BUSY = 0;
`else
  localparam int ZERO_BUSY = 4;
`endif

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [N-1:0]   A_num;
  logic [N-1:0]   B_num;
  logic           busy;
  logic           done;
  logic [2*N-1:0] result;

  int tests_run;
  int tests_failed;
  int done_seen;

  multiplicador_n #(.N(N)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .A_num  (A_num),
    .B_num  (B_num),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and count any done pulse seen there.
  task automatic tick();
    @(negedge clk);
    if (done) done_seen++;
  endtask

  // Called on a falling edge just after the start was accepted.
  task automatic finish_mult(input string tag, input logic [7:0] exp, input int exp_busy);
    int bc;
    bc = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) break;
      if (busy) bc++;
      tick();
    end
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_busy_cycles"}, bc, exp_busy);
    check({tag, "_result"}, {24'd0, result}, {24'd0, exp});
    tick();
    check({tag, "_done_gone"}, {31'd0, done}, 32'd0);
    check({tag, "_result_held"}, {24'd0, result}, {24'd0, exp});
  endtask

  // Called on a falling edge in IDLE. Returns on a falling edge in IDLE.
  task automatic do_mult(input string tag, input logic [3:0] a, input logic [3:0] b,
                         input logic [7:0] exp, input int exp_busy);
    A_num = a;
    B_num = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    A_num = 4'h0;
    B_num = 4'h0;
    finish_mult(tag, exp, exp_busy);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    done_seen    = 0;
    rst_n = 1'b0;
    start = 1'b0;
    A_num = '0;
    B_num = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", {24'd0, result}, 32'd0);
    rst_n = 1'b1;
    tick();

    do_mult("m3x5", 4'h3, 4'h5, 8'h0F, 4);
    do_mult("mFxF", 4'hF, 4'hF, 8'hE1, 4);
    do_mult("m9x0", 4'h9, 4'h0, 8'h00, ZERO_BUSY);
    do_mult("m5x7", 4'h5, 4'h7, 8'h23, 4);

    // Starts pulsed during CALC and during DONE must be ignored.
    done_seen = 0;
    A_num = 4'h7;
    B_num = 4'h6;
    start = 1'b1;
    tick();
    start = 1'b0;
    A_num = 4'h2;
    B_num = 4'h2;
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ign_busy_mid", {31'd0, busy}, 32'd1);
    tick();
    check("ign_done", {31'd0, done}, 32'd1);
    check("ign_result", {24'd0, result}, 32'h2A);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    check("ign_busy_after", {31'd0, busy}, 32'd0);
    check("ign_result_after", {24'd0, result}, 32'h2A);
    check("ign_done_pulses", done_seen, 32'd1);

    // Asynchronous reset while the multiplier is iterating.
    A_num = 4'hA;
    B_num = 4'hB;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("arst_busy_before", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_result", {24'd0, result}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    do_mult("mAxB", 4'hA, 4'hB, 8'h6E, 4);

    // Back-to-back: second start at the first legal edge.
    do_mult("b2b_1x1", 4'h1, 4'h1, 8'h01, 4);
    A_num = 4'hC;
    B_num = 4'h3;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("b2b_busy", {31'd0, busy}, 32'd1);
    check("b2b_result_kept", {24'd0, result}, 32'h01);
    finish_mult("b2b_Cx3", 8'h24, 4);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
